pe_collision_stream: RTL and testbench

Column-sweep front end for the HPP processing element: reads one column of packed cell-pair words from lattice memory, applies the HPP collision rule to both cells of each word, and streams the results one word per clock into the propagation stage's `right_state` input. The block also generates the write-back address and enable. These are delayed to line up with the propagation stage's two-deep history, so the sweep controller only issues `start` and waits for `done`.

---
 rtl/pe_collision_stream.sv | 88 ++++++++
 tb/tb_pe_collision_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pe_collision_stream.sv
// pe_collision_stream: column sweep that reads cell-pair words, applies the HPP collision rule and
// streams them out with a delayed write-back strobe. Define PE_WALL_REFLECT_EN to reflect at wall cells.
module pe_collision_stream #(
    parameter int ROWS_PAIRS = 240,
    parameter int ADDR_W     = 8,
    parameter int WB_DELAY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [9:0]        rd_data,
    output logic [9:0]        right_state,
    output logic              state_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS_PAIRS - 1);
    state_t              state_q;
    logic                busy_q, done_q, rd_en_q, pend_q, sv_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [9:0]          rs_q, rs_d;
    logic [WB_DELAY-1:0] wb_q;
    function automatic logic [4:0] collide(input logic [4:0] c);
`ifdef PE_WALL_REFLECT_EN
        if (c[4]) return {c[4], c[1:0], c[3:2]};
`endif
        return {c[4], (c[3:0] == 4'b0101) ? 4'b1010 : (c[3:0] == 4'b1010) ? 4'b0101 : c[3:0]};
    endfunction
    // pend_q marks the cycle in which rd_data holds the word requested one cycle earlier
    assign rs_d = pend_q ? {collide(rd_data[9:5]), collide(rd_data[4:0])} : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            pend_q    <= 1'b0;
            sv_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rs_q      <= '0;
            wb_q      <= '0;
        end else begin
            pend_q <= rd_en_q;
            sv_q   <= pend_q;
            rs_q   <= rs_d;
            wb_q   <= WB_DELAY'({wb_q, sv_q});
            if (wr_en) wr_addr_q <= wr_addr_q + 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= READ;
                    busy_q    <= 1'b1;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                    wr_addr_q <= '0;
                end
                READ: if (rd_addr_q == LAST) begin
                    state_q <= DRAIN;
                    rd_en_q <= 1'b0;
                end else begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                end
                DRAIN: if (wr_en && wr_addr_q == LAST) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign right_state = rs_q;
    assign state_valid = sv_q;
    assign wr_en       = wb_q[WB_DELAY-1];
    assign wr_addr     = wr_addr_q;
endmodule

// File: tb/tb_pe_collision_stream.sv
// tb_pe_collision_stream: randomized and directed sweeps checked against a cycle-indexed reference
// derived from the sweep timing rules and a behavioural collision model.
module tb_pe_collision_stream;
    localparam int N = 4, AW = 8, D = 2;
    logic          clk = 1'b0, reset, start;
    logic          busy, done, rd_en, state_valid, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [9:0]    rd_data, right_state;
    logic [9:0]    mem [N];
    logic [9:0]    got [N];
    int            total = 0, bad = 0;

    pe_collision_stream #(.ROWS_PAIRS(N), .ADDR_W(AW), .WB_DELAY(D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .right_state(right_state),
        .state_valid(state_valid), .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[1:0]] : 10'($urandom);

    function automatic logic [4:0] ref_cell(input logic [4:0] c);
        logic [3:0] d;
        d = c[3:0];
`ifdef PE_WALL_REFLECT_EN
        if (c[4]) return {1'b1, d[1], d[0], d[3], d[2]};
`endif
        if (d == 4'h5 || d == 4'hA) d = ~d;
        return {c[4], d};
    endfunction

    function automatic logic [9:0] ref_word(input logic [9:0] w);
        return {ref_cell(w[9:5]), ref_cell(w[4:0])};
    endfunction

    task automatic do_sweep(input string name, input bit mid_start);
        logic       e_busy, e_done, e_rd, e_sv, e_wr;
        logic [9:0] e_rs;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t <= N + D + 4; t++) begin
            if (mid_start) start = (t == 2);
            e_rd   = t < N;
            e_sv   = t >= 2 && t <= N + 1;
            e_wr   = t >= 2 + D && t <= N + 1 + D;
            e_done = t == N + 2 + D;
            e_busy = t <= N + 2 + D;
            e_rs   = e_sv ? ref_word(mem[t-2]) : 10'd0;
            if (e_sv) got[t-2] = right_state;
            total++;
            if ({busy, done, rd_en, state_valid, wr_en} !== {e_busy, e_done, e_rd, e_sv, e_wr}) begin
                bad++;
                $display("FAIL %s ctrl t0+%0d got=%b exp=%b", name, t,
                         {busy, done, rd_en, state_valid, wr_en}, {e_busy, e_done, e_rd, e_sv, e_wr});
            end
            total++;
            if (right_state !== e_rs) begin
                bad++;
                $display("FAIL %s right_state t0+%0d got=%h exp=%h", name, t, right_state, e_rs);
            end
            if (e_rd) begin
                total++;
                if (rd_addr !== AW'(t)) begin
                    bad++;
                    $display("FAIL %s rd_addr t0+%0d got=%0d exp=%0d", name, t, rd_addr, t);
                end
            end
            if (e_wr) begin
                total++;
                if (wr_addr !== AW'(t - 2 - D)) begin
                    bad++;
                    $display("FAIL %s wr_addr t0+%0d got=%0d exp=%0d", name, t, wr_addr, t - 2 - D);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        #1;
        repeat (3) begin
            total++;
            if ({busy, done, rd_en, state_valid, wr_en, rd_addr, wr_addr, right_state} !== '0) begin
                bad++;
                $display("FAIL reset outputs got=%b exp=0",
                         {busy, done, rd_en, state_valid, wr_en, rd_addr, wr_addr, right_state});
            end
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic test_head_on();
        foreach (mem[i]) mem[i] = 10'($urandom);
        mem[0] = 10'h0A5;
        do_sweep("head_on", 1'b0);
        total++;
        if (got[0] !== 10'h14A) begin
            bad++;
            $display("FAIL head_on word got=%h exp=14a", got[0]);
        end
    endtask

    task automatic test_wall();
        logic [9:0] exp;
`ifdef PE_WALL_REFLECT_EN
        exp = {5'b10010, 5'b10100};
`else
        exp = {5'b11000, 5'b10001};
`endif
        foreach (mem[i]) mem[i] = 10'($urandom);
        mem[0] = {5'b11000, 5'b10001};
        do_sweep("wall", 1'b0);
        total++;
        if (got[0] !== exp) begin
            bad++;
            $display("FAIL wall word got=%h exp=%h", got[0], exp);
        end
    endtask

    task automatic test_passthrough();
        foreach (mem[i]) mem[i] = 10'($urandom);
        mem[0] = {5'b00000, 5'b00111};
        mem[1] = 10'h3FF;
        do_sweep("passthrough", 1'b0);
        total++;
        if (got[0] !== 10'h007 || got[1] !== 10'h3FF) begin
            bad++;
            $display("FAIL passthrough words got=%h,%h exp=007,3ff", got[0], got[1]);
        end
    endtask

    task automatic test_mid_start();
        foreach (mem[i]) mem[i] = 10'($urandom);
        do_sweep("mid_start", 1'b1);
        repeat (4) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_start extra activity got done=%b busy=%b exp 0,0", done, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        foreach (mem[i]) mem[i] = 10'($urandom);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, rd_en, state_valid, wr_en, rd_addr, wr_addr, right_state} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs got=%b exp=0",
                     {busy, done, rd_en, state_valid, wr_en, rd_addr, wr_addr, right_state});
        end
        @(negedge clk) reset = 1'b0;
        repeat (8) begin
            total++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid after release got wr_en=%b busy=%b exp 0,0", wr_en, busy);
            end
            @(negedge clk);
        end
        do_sweep("reset_resweep", 1'b0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 20; s++) begin
            foreach (mem[i]) mem[i] = 10'($urandom);
            if (s % 3 == 0) mem[$urandom_range(N - 1)] = ($urandom_range(1) != 0) ? 10'h0A5 : 10'h14A;
            do_sweep("random", 1'b0);
            repeat ($urandom_range(2)) @(negedge clk);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_head_on();
        test_wall();
        test_passthrough();
        test_mid_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
